ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch initiator for the NPC core; the requesting side of the instruction-memory interface.
- Holds the PC and issues one fetch request at a time to the instruction memory.
- Captures the returned instruction word and presents {pc, inst} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute and discards any stale in-flight fetch.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset (start of instruction memory).
XLEN, 32, address/instruction width.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  out  1  fetch request valid.
req_addr  out  XLEN  fetch address; always the current pc, bits [1:0] always 0.
req_ready  in  1  memory accepts the request this cycle.
rsp_valid  in  1  instruction word returned this cycle (one-cycle pulse).
rsp_data  in  32  returned instruction word.
redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored (forced to 0).
out_valid  out  1  instruction available to decode.
out_pc  out  XLEN  PC of the presented instruction.
out_inst  out  32  presented instruction word.
out_ready  in  1  decode accepts the instruction this cycle.

Behaviour:
- Reset (asynchronous, active-high): state=BOOT, pc=RESET_PC, kill=0, out_inst=0, out_pc=RESET_PC.
- During reset: req_valid=0, out_valid=0.
- All outputs derive from registers only; there is no combinational path from any input to any output.
- req_valid = (state==REQ). out_valid = (state==HOLD).
- Only one request is outstanding at a time. The memory must not assert rsp_valid unless the block is in WAIT; rsp_valid in any other state is ignored.

States:
- BOOT: go to REQ on the next cycle. The first request is therefore issued the cycle after reset deasserts.
- REQ: drive req_valid=1, req_addr=pc.
  - req_ready=1: go to WAIT.
  - req_ready=0: stay in REQ; address held stable.
- WAIT: wait for rsp_valid.
  - rsp_valid=1 with kill=0: out_inst<=rsp_data, out_pc<=pc, go to HOLD.
  - rsp_valid=1 with kill=1: discard the word, clear kill, go to REQ.
- HOLD: out_valid=1; out_pc and out_inst are held stable until accepted.
  - out_ready=1: pc<=pc+4, go to REQ.

Timing:
- Best-case fetch-to-decode time is 2 cycles plus memory latency: REQ handshake cycle, then WAIT for at least one cycle, then HOLD.
- Sustained throughput is at most one instruction per 3 cycles. This block is non-pipelined by design.

Redirect (highest priority, evaluated every state, pc<={redirect_pc[31:2],2'b00}):
- In BOOT: pc<=target; next state REQ.
- In REQ, req_ready=0: go to REQ with the new address. Changing the address of an unaccepted request is permitted only on redirect.
- In REQ, req_ready=1 in the same cycle: the old-address request is accepted. Set kill=1 and go to WAIT.
- In WAIT, rsp_valid=0: set kill=1, stay in WAIT.
- In WAIT, rsp_valid=1: discard the word, kill=0, go to REQ.
- In HOLD: drop the held instruction and go to REQ; out_valid=0 next cycle.
  - If out_ready=1 in the same cycle, the decode handshake still completes (decode owns that instruction), but pc takes the redirect target, not pc+4.
- Repeated redirects while kill=1: pc takes the latest target; kill stays 1; only one response is discarded.

Arithmetic:
- pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 with no flag.
- Reset asserted mid-operation (any state, kill set or not) returns to BOOT at once. A response arriving after reset deasserts and before the first request is ignored, because the block is in BOOT/REQ.

Test Plan:
- Reset release, memory answers 1 cycle after acceptance with 32'h0050_0513 -> req_addr=32'h8000_0000; out_valid rises 3 cycles after the first req_valid; out_pc=32'h8000_0000; out_inst=32'h0050_0513.
- Sequential: out_ready tied 1, responses 32'hA, 32'hB, 32'hC -> out_pc sequence 32'h8000_0000, 32'h8000_0004, 32'h8000_0008 with matching instructions.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_pc and out_inst stable and req_valid=0; then out_ready=1 -> next req_addr = out_pc+4.
- Redirect in WAIT to 32'h8000_0101 while the response is 2 cycles away -> that response is not presented; next req_addr=32'h8000_0100; its instruction is presented with out_pc=32'h8000_0100.
- Corner cases:
  - Redirect to 32'h8000_0040 in the same cycle as the req_ready handshake -> the next response is discarded, then fetch at 32'h8000_0040.
  - Redirect together with out_ready in HOLD -> one instruction is consumed, then fetch at the target.
- Stress cases:
  - Async reset pulsed mid-WAIT (between clock edges) -> req_valid and out_valid drop immediately; fetch restarts at 32'h8000_0000.
  - pc=32'hFFFF_FFFC accepted -> next req_addr=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction-fetch initiator: holds the PC, issues one request at a time, hands {pc, inst} to decode.
// Latency: request handshake, then at least one WAIT cycle, then HOLD (>= 2 cycles + memory latency).
// Backpressure: req_ready=0 holds REQ with a stable address; out_ready=0 holds HOLD with stable pc/inst.
module ifu_fetch #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    input  logic            out_ready
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            kill, kill_nxt;
    logic            capture;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        capture   = 1'b0;
        case (state)
            BOOT: state_nxt = REQ;
            REQ: begin
                if (req_ready) begin
                    state_nxt = WAIT;
                    // The old-address request is already out; its reply must be dropped.
                    if (redirect_valid) kill_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    kill_nxt = 1'b0;
                    if (kill || redirect_valid) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt = HOLD;
                        capture   = 1'b1;
                    end
                end else if (redirect_valid) begin
                    kill_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_nxt = REQ;
                end else if (out_ready) begin
                    pc_nxt    = pc + XLEN'(4);
                    state_nxt = REQ;
                end
            end
            default: state_nxt = BOOT;
        endcase
        // Redirect overrides any sequential pc update, including a completing decode handshake.
        if (redirect_valid) pc_nxt = redirect_tgt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            out_pc   <= RESET_PC;
            out_inst <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            if (capture) begin
                out_pc   <= pc;
                out_inst <= rsp_data;
            end
        end
    end

    assign req_valid = (state == REQ);
    assign req_addr  = pc;
    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: per-cycle vector table plus hand-written async-reset sequences.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ready      (out_ready)
    );

    // Each row: outputs expected at this falling edge, then inputs driven for the next rising edge.
    typedef struct {
        logic        rst;
        logic        rr;
        logic        sv;
        logic [31:0] sd;
        logic        dv;
        logic [31:0] dpc;
        logic        ordy;
        logic        erv;
        logic [31:0] era;
        logic        eov;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rr, logic sv, logic [31:0] sd, logic dv,
                                logic [31:0] dpc, logic ordy, logic erv, logic [31:0] era,
                                logic eov, logic [31:0] epc, logic [31:0] einst);
        vec_t v;
        v.rst = r;  v.rr = rr;   v.sv = sv;   v.sd = sd;   v.dv = dv;   v.dpc = dpc;
        v.ordy = ordy; v.erv = erv; v.era = era; v.eov = eov; v.epc = epc; v.einst = einst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic erv, input logic [31:0] era,
                           input logic eov, input logic [31:0] epc, input logic [31:0] einst);
        chk({tag, ".req_valid"}, {31'd0, req_valid}, {31'd0, erv});
        chk({tag, ".req_addr"},  req_addr, era);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
        chk({tag, ".out_pc"},    out_pc, epc);
        chk({tag, ".out_inst"},  out_inst, einst);
    endtask

    localparam logic [31:0] RP = 32'h8000_0000;

    initial begin
        // Reset release, first fetch, then 5-cycle backpressure in HOLD.
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,RP,0,RP,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,RP,0,RP,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,RP,0,RP,0));
        vecs.push_back(mk(0,0,1,32'h0050_0513,0,0,0, 0,RP,0,RP,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0,0,0,0,0, 0,RP,1,RP,32'h0050_0513));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,RP,1,RP,32'h0050_0513));
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,32'h8000_0004,0,RP,32'h0050_0513));
        // Fresh start: sequential fetch with out_ready tied high.
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,RP,0,RP,0));
        vecs.push_back(mk(0,1,0,0,0,0,1, 1,RP,0,RP,0));
        vecs.push_back(mk(0,0,1,32'hA,0,0,1, 0,RP,0,RP,0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,RP,1,RP,32'hA));
        vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h8000_0004,0,RP,32'hA));
        vecs.push_back(mk(0,0,1,32'hB,0,0,1, 0,32'h8000_0004,0,RP,32'hA));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,32'h8000_0004,1,32'h8000_0004,32'hB));
        vecs.push_back(mk(0,1,0,0,0,0,1, 1,32'h8000_0008,0,32'h8000_0004,32'hB));
        vecs.push_back(mk(0,0,1,32'hC,0,0,1, 0,32'h8000_0008,0,32'h8000_0004,32'hB));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,32'h8000_0008,1,32'h8000_0008,32'hC));
        // Redirect in WAIT, response two cycles later is dropped.
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8000_000C,0,32'h8000_0008,32'hC));
        vecs.push_back(mk(0,0,0,0,1,32'h8000_0101,0, 0,32'h8000_000C,0,32'h8000_0008,32'hC));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h8000_0100,0,32'h8000_0008,32'hC));
        vecs.push_back(mk(0,0,1,32'hDEAD_0001,0,0,0, 0,32'h8000_0100,0,32'h8000_0008,32'hC));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8000_0100,0,32'h8000_0008,32'hC));
        vecs.push_back(mk(0,0,1,32'h1111_1111,0,0,0, 0,32'h8000_0100,0,32'h8000_0008,32'hC));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,32'h8000_0100,1,32'h8000_0100,32'h1111_1111));
        // Redirect coincident with the request handshake.
        vecs.push_back(mk(0,1,0,0,1,32'h8000_0040,0, 1,32'h8000_0104,0,32'h8000_0100,32'h1111_1111));
        vecs.push_back(mk(0,0,1,32'h2222_2222,0,0,0, 0,32'h8000_0040,0,32'h8000_0100,32'h1111_1111));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8000_0040,0,32'h8000_0100,32'h1111_1111));
        vecs.push_back(mk(0,0,1,32'h3333_3333,0,0,0, 0,32'h8000_0040,0,32'h8000_0100,32'h1111_1111));
        // Redirect together with out_ready in HOLD.
        vecs.push_back(mk(0,0,0,0,1,32'h8000_0203,1, 0,32'h8000_0040,1,32'h8000_0040,32'h3333_3333));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8000_0200,0,32'h8000_0040,32'h3333_3333));
        vecs.push_back(mk(0,0,1,32'h4444_4444,0,0,0, 0,32'h8000_0200,0,32'h8000_0040,32'h3333_3333));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,32'h8000_0200,1,32'h8000_0200,32'h4444_4444));
        // Redirect of an unaccepted request, then repeated redirects while kill is set.
        vecs.push_back(mk(0,0,0,0,1,32'h8000_0300,0, 1,32'h8000_0204,0,32'h8000_0200,32'h4444_4444));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8000_0300,0,32'h8000_0200,32'h4444_4444));
        vecs.push_back(mk(0,0,0,0,1,32'h8000_0400,0, 0,32'h8000_0300,0,32'h8000_0200,32'h4444_4444));
        vecs.push_back(mk(0,0,0,0,1,32'h8000_0500,0, 0,32'h8000_0400,0,32'h8000_0200,32'h4444_4444));
        vecs.push_back(mk(0,0,1,32'h6666_6666,0,0,0, 0,32'h8000_0500,0,32'h8000_0200,32'h4444_4444));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8000_0500,0,32'h8000_0200,32'h4444_4444));
        vecs.push_back(mk(0,0,1,32'h7777_7777,0,0,0, 0,32'h8000_0500,0,32'h8000_0200,32'h4444_4444));
        // Stray response in HOLD is ignored.
        vecs.push_back(mk(0,0,1,32'h9999_9999,0,0,0, 0,32'h8000_0500,1,32'h8000_0500,32'h7777_7777));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,32'h8000_0500,1,32'h8000_0500,32'h7777_7777));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h8000_0504,0,32'h8000_0500,32'h7777_7777));
        vecs.push_back(mk(0,0,1,32'h8888_8888,0,0,0, 0,32'h8000_0504,0,32'h8000_0500,32'h7777_7777));
        // Redirect in HOLD without decode acceptance.
        vecs.push_back(mk(0,0,0,0,1,32'h8000_0600,0, 0,32'h8000_0504,1,32'h8000_0504,32'h8888_8888));
        // Wrap of pc+4 at the top of the address space.
        vecs.push_back(mk(0,0,0,0,1,32'hFFFF_FFFF,0, 1,32'h8000_0600,0,32'h8000_0504,32'h8888_8888));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'hFFFF_FFFC,0,32'h8000_0504,32'h8888_8888));
        vecs.push_back(mk(0,0,1,32'hABCD_0000,0,0,0, 0,32'hFFFF_FFFC,0,32'h8000_0504,32'h8888_8888));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,32'hABCD_0000));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,32'h0000_0000,0,32'hFFFF_FFFC,32'hABCD_0000));

        @(negedge clk);
        chk_all("reset", 1'b0, RP, 1'b0, RP, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].erv, vecs[i].era, vecs[i].eov,
                    vecs[i].epc, vecs[i].einst);
            rst            = vecs[i].rst;
            req_ready      = vecs[i].rr;
            rsp_valid      = vecs[i].sv;
            rsp_data       = vecs[i].sd;
            redirect_valid = vecs[i].dv;
            redirect_pc    = vecs[i].dpc;
            out_ready      = vecs[i].ordy;
        end

        // Async reset pulsed between edges while WAIT holds a kill.
        @(negedge clk);
        chk_all("wait0", 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'hABCD_0000);
        req_ready = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0700;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("wait_kill.req_addr", req_addr, 32'h8000_0700);
        #2 rst = 1'b1;
        #1 chk_all("arst_wait", 1'b0, RP, 1'b0, RP, 32'd0);
        #1 rst = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'h0BAD_0BAD;
        @(negedge clk);
        chk_all("restart_req", 1'b1, RP, 1'b0, RP, 32'd0);
        rsp_valid = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        chk_all("restart_wait", 1'b0, RP, 1'b0, RP, 32'd0);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk_all("restart_hold", 1'b0, RP, 1'b1, RP, 32'h1234_5678);
        // Async reset pulsed mid-HOLD drops out_valid immediately.
        #2 rst = 1'b1;
        #1 chk_all("arst_hold", 1'b0, RP, 1'b0, RP, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all("post_hold_req", 1'b1, RP, 1'b0, RP, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
